// File: rtl/load_store_unit.sv
// Memory-access stage: byte/half/word loads with lane extraction and extension,
// sub-word stores via read-modify-write against a single whole-word write enable.
module load_store_unit #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, WR = 2'd2, RESP = 2'd3} state_t;

  state_t      state, state_next;
  logic [2:0]  cnt, cnt_next;
  logic [1:0]  off, off_next;
  logic [1:0]  size, size_next;
  logic        we, we_next;
  logic        uns, uns_next;
  logic [15:0] wdata, wdata_next;
  logic        mem_we_next;
  logic [31:0] mem_addr_next, mem_wd_next;
  logic        resp_valid_next, resp_err_next;
  logic [31:0] resp_rdata_next;

  logic        accept, misaligned, last_wait;
  logic [3:0]  lane_en;
  logic [31:0] merged, load_data;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign req_ready  = rstn && (state == IDLE);
  assign accept     = req_valid && req_ready;
  assign misaligned = (req_size == 2'b11) ||
                      (req_size == 2'b01 && req_addr[0]) ||
                      (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign last_wait  = (cnt == 3'd1);

  // Store merge: replace the addressed lanes, keep the rest of the word just read.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign lane_en[gi] = (size == 2'b00) ? (off == LANE) : (off[1] == LANE[1]);
      assign merged[8*gi +: 8] = !lane_en[gi]     ? mem_rd[8*gi +: 8] :
                                 (size == 2'b00) ? wdata[7:0]        :
                                                   wdata[8*(gi%2) +: 8];
    end
  endgenerate

  assign byte_lane = mem_rd[{off, 3'b000} +: 8];
  assign half_lane = off[1] ? mem_rd[31:16] : mem_rd[15:0];

  always_comb begin
    case (size)
      2'b00:   load_data = {{24{!uns && byte_lane[7]}}, byte_lane};
      2'b01:   load_data = {{16{!uns && half_lane[15]}}, half_lane};
      default: load_data = mem_rd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      off        <= '0;
      size       <= '0;
      we         <= 1'b0;
      uns        <= 1'b0;
      wdata      <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wd     <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      off        <= off_next;
      size       <= size_next;
      we         <= we_next;
      uns        <= uns_next;
      wdata      <= wdata_next;
      mem_we     <= mem_we_next;
      mem_addr   <= mem_addr_next;
      mem_wd     <= mem_wd_next;
      resp_valid <= resp_valid_next;
      resp_rdata <= resp_rdata_next;
      resp_err   <= resp_err_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misaligned)                       state_next = RESP;
          else if (req_we && req_size == 2'b10) state_next = WR;
          else                                  state_next = RD_WAIT;
        end
      end
      RD_WAIT: if (last_wait) state_next = we ? WR : RESP;
      WR:      state_next = RESP;
      default: state_next = IDLE;
    endcase
  end

  // Next values for the registered outputs and the latched request.
  always_comb begin
    cnt_next        = cnt;
    off_next        = off;
    size_next       = size;
    we_next         = we;
    uns_next        = uns;
    wdata_next      = wdata;
    mem_we_next     = 1'b0;
    mem_addr_next   = mem_addr;
    mem_wd_next     = mem_wd;
    resp_valid_next = 1'b0;
    resp_rdata_next = '0;
    resp_err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          off_next   = req_addr[1:0];
          size_next  = req_size;
          we_next    = req_we;
          uns_next   = req_unsigned;
          wdata_next = req_wdata[15:0];
          if (misaligned) begin
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
          end else begin
            mem_addr_next = {req_addr[31:2], 2'b00};
            cnt_next      = 3'(MEM_LAT);
            if (req_we && req_size == 2'b10) begin
              mem_we_next = 1'b1;
              mem_wd_next = req_wdata;
            end
          end
        end
      end
      RD_WAIT: begin
        cnt_next = cnt - 3'd1;
        if (last_wait) begin
          if (we) begin
            mem_we_next = 1'b1;
            mem_wd_next = merged;
          end else begin
            resp_valid_next = 1'b1;
            resp_rdata_next = load_data;
          end
        end
      end
      WR:      resp_valid_next = 1'b1;
      default: ;
    endcase
  end

endmodule
